// File: rtl/can_tx_fifo.sv
// CAN TX frame FIFO: circular buffer with registered read port, count-derived flags.
// Optional sticky overflow/underflow flags when CAN_TX_FIFO_ERR_EN is defined.
module can_tx_fifo #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       i_sys_clk,
  input  logic                       i_reset_n,
  input  logic                       i_w_en,
  input  logic [DATA_W-1:0]          i_w_data,
  input  logic                       i_r_en,
  output logic [DATA_W-1:0]          o_r_data,
  output logic                       o_tx_empty,
  output logic                       o_full,
  output logic                       o_afull,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic                       i_flush,
  output logic                       o_overflow,
  output logic                       o_underflow,
  input  logic                       i_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_drop;
  logic              rd_drop;

  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    // Flush wins over everything in the same cycle, including error detection.
    wr_acc  = i_w_en && !full  && !i_flush;
    rd_acc  = i_r_en && !empty && !i_flush;
    wr_drop = i_w_en && full   && !i_flush;
    rd_drop = i_r_en && empty  && !i_flush;
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally not reset; reads are gated by a non-zero count.
  always_ff @(posedge i_sys_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_w_data;
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n)  o_r_data <= '0;
    else if (rd_acc) o_r_data <= mem[rd_ptr];
  end

  assign o_tx_empty = empty;
  assign o_full     = full;
  assign o_afull    = (count >= CW'(AFULL_THRESH));
  assign o_count    = count;

`ifdef CAN_TX_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_drop)        ovf_q <= 1'b1;
      else if (i_err_clr) ovf_q <= 1'b0;
      if (rd_drop)        unf_q <= 1'b1;
      else if (i_err_clr) unf_q <= 1'b0;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_err;
  assign unused_err  = i_err_clr ^ wr_drop ^ rd_drop;
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_fifo.sv
// Bench for can_tx_fifo: vector table, directed corner sequences, random traffic vs queue model.
module tb_can_tx_fifo;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 8;
  localparam int AFT    = DEPTH - 2;
`ifdef CAN_TX_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en, r_en, flush, err_clr;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              tx_empty, full, afull, overflow, underflow;
  logic [3:0]        count;

  int checks = 0;
  int errors = 0;

  can_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .i_sys_clk(clk), .i_reset_n(rst_n), .i_w_en(w_en), .i_w_data(w_data),
    .i_r_en(r_en), .o_r_data(r_data), .o_tx_empty(tx_empty), .o_full(full),
    .o_afull(afull), .o_count(count), .i_flush(flush), .o_overflow(overflow),
    .o_underflow(underflow), .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: occupancy is just the queue, error flags are plain bits.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rdata;
  logic              m_ovf, m_unf;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [DATA_W-1:0] wd, input logic r,
                            input logic fl, input logic clr);
    int  n;
    bit  o_set, u_set;
    n = q.size();
    o_set = ERR && !fl && w && (n == DEPTH);
    u_set = ERR && !fl && r && (n == 0);
    if (fl) q.delete();
    else begin
      if (r && n > 0) m_rdata = q.pop_front();
      if (w && n < DEPTH) q.push_back(wd);
    end
    if (ERR) begin
      m_ovf = o_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = u_set ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, DATA_W'(count), DATA_W'(n));
    chk({tag, ".empty"}, DATA_W'(tx_empty), DATA_W'(n == 0));
    chk({tag, ".full"},  DATA_W'(full), DATA_W'(n == DEPTH));
    chk({tag, ".afull"}, DATA_W'(afull), DATA_W'(n >= AFT));
    chk({tag, ".rdata"}, r_data, m_rdata);
    chk({tag, ".ovf"},   DATA_W'(overflow), DATA_W'(m_ovf));
    chk({tag, ".unf"},   DATA_W'(underflow), DATA_W'(m_unf));
  endtask

  // Called just after an edge; drives inputs, clocks once, checks against the model.
  task automatic apply(input string tag, input logic w, input logic [DATA_W-1:0] wd,
                       input logic r, input logic fl, input logic clr);
    w_en = w; w_data = wd; r_en = r; flush = fl; err_clr = clr;
    @(posedge clk);
    model_step(w, wd, r, fl, clr);
    #1;
    check_all(tag);
  endtask

  function automatic logic [DATA_W-1:0] word(input int v);
    return {16{8'(v)}};
  endfunction

  typedef struct {
    logic              w;
    logic [DATA_W-1:0] wd;
    logic              r;
    logic [3:0]        ecount;
    logic              eafull;
    logic [DATA_W-1:0] erd;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_n = 1'b0; w_en = 0; r_en = 0; flush = 0; err_clr = 0; w_data = '0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tbl[i]   = '{w: 1'b1, wd: word(i + 1), r: 1'b0, ecount: 4'(i + 1),
                   eafull: (i + 1) >= 6, erd: '0};
      tbl[8+i] = '{w: 1'b0, wd: '0, r: 1'b1, ecount: 4'(7 - i),
                   eafull: (7 - i) >= 6, erd: word(i + 1)};
    end

    #23;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full and drain in order.
    for (int i = 0; i < 16; i++) begin
      apply("tbl", tbl[i].w, tbl[i].wd, tbl[i].r, 1'b0, 1'b0);
      chk("tbl.count", DATA_W'(count), DATA_W'(tbl[i].ecount));
      chk("tbl.afull", DATA_W'(afull), DATA_W'(tbl[i].eafull));
      if (tbl[i].r) chk("tbl.rdata", r_data, tbl[i].erd);
      if (i == 7) chk("tbl.full", DATA_W'(full), 1);
    end
    chk("tbl.empty_end", DATA_W'(tx_empty), 1);

    // Full with simultaneous read and write: oldest read, write dropped.
    for (int i = 0; i < 8; i++) apply("fill", 1'b1, word(8'h20 + i), 1'b0, 1'b0, 1'b0);
    apply("fullrw", 1'b1, word(8'hEE), 1'b1, 1'b0, 1'b0);
    chk("fullrw.rdata", r_data, word(8'h20));
    chk("fullrw.count", DATA_W'(count), 7);
    chk("fullrw.ovf", DATA_W'(overflow), DATA_W'(ERR));
    apply("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr.ovf", DATA_W'(overflow), 0);

    // Empty read: data holds, underflow flagged then cleared.
    apply("flush0", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    apply("emptyrd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("emptyrd.rdata", r_data, word(8'h20));
    chk("emptyrd.unf", DATA_W'(underflow), DATA_W'(ERR));
    apply("empty_rw", 1'b1, word(8'h55), 1'b1, 1'b0, 1'b0);
    chk("empty_rw.count", DATA_W'(count), 1);
    apply("clr_set", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("single.rdata", r_data, word(8'h55));
    chk("single.empty", DATA_W'(tx_empty), 1);
    apply("set_over_clr", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("set_over_clr.unf", DATA_W'(underflow), DATA_W'(ERR));
    apply("clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr2.unf", DATA_W'(underflow), 0);

    // Count 4, 20 cycles of concurrent read/write across pointer wrap.
    for (int i = 0; i < 4; i++) apply("pre4", 1'b1, word(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply("rw", 1'b1, word(8'h44 + i), 1'b1, 1'b0, 1'b0);
      chk("rw.count", DATA_W'(count), 4);
      chk("rw.rdata", r_data, word(8'h40 + i));
    end

    // Count 5, flush with write: everything dropped, no flags.
    apply("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    apply("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    apply("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    apply("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply("pre5", 1'b1, word(8'h70 + i), 1'b0, 1'b0, 1'b0);
    apply("flushw", 1'b1, word(8'h99), 1'b1, 1'b1, 1'b0);
    chk("flushw.count", DATA_W'(count), 0);
    chk("flushw.ovf", DATA_W'(overflow), 0);
    apply("postfl_w", 1'b1, word(8'hA1), 1'b0, 1'b0, 1'b0);
    apply("postfl_r", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("postfl.rdata", r_data, word(8'hA1));

    // Count 3, asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) apply("pre3", 1'b1, word(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    w_en = 0; r_en = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");
    apply("prst_w", 1'b1, word(8'hC3), 1'b0, 1'b0, 1'b0);
    apply("prst_r", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("prst.rdata", r_data, word(8'hC3));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      apply("rand", ($urandom_range(0, 9) < 6), d, ($urandom_range(0, 9) < 5),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_tx_fifo.md
CAN_TX_FIFO -- requirements
Module: can_tx_fifo

Interface
REQ-001 Parameter DATA_W, 128, frame word width in bits.
REQ-002 Parameter DEPTH, 8, number of entries; power of two, minimum 2.
REQ-003 Parameter AFULL_THRESH, DEPTH-2, count at or above which o_afull asserts.
REQ-004 i_sys_clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_w_en  input  1  host write request, one entry per cycle high.
REQ-007 i_w_data  input  DATA_W  frame word to store.
REQ-008 i_r_en  input  1  read request from the TX priority logic.
REQ-009 o_r_data  output  DATA_W  registered read word; feeds priority-logic i_fifo_data.
REQ-010 o_tx_empty  output  1  count==0; feeds priority-logic i_tx_empty.
REQ-011 o_full  output  1  count==DEPTH.
REQ-012 o_afull  output  1  count>=AFULL_THRESH.
REQ-013 o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 i_flush  input  1  synchronous discard of all entries.
REQ-015 o_overflow, o_underflow  output  1 each  sticky error flags (CAN_TX_FIFO_ERR_EN only).
REQ-016 i_err_clr  input  1  clears sticky flags (CAN_TX_FIFO_ERR_EN only).

Function
REQ-017 Storage: circular buffer; wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; count tracked separately.
REQ-018 Write accepted when i_w_en=1 and o_full=0: mem[wr_ptr]<=i_w_data, wr_ptr+1.
REQ-019 Read accepted when i_r_en=1 and o_tx_empty=0: o_r_data<=mem[rd_ptr], rd_ptr+1; data valid the edge after i_r_en sampled (1-cycle latency).
REQ-020 No first-word fall-through; o_r_data holds last read value between reads.
REQ-021 Simultaneous accepted read and write: count unchanged, both pointers advance.
REQ-022 Write when full is dropped even if read same cycle; memory and wr_ptr unchanged.
REQ-023 Read when empty is ignored even if write same cycle; o_r_data unchanged, written word stored.
REQ-024 Flags o_tx_empty, o_full, o_afull, o_count are registered/derived from count and reflect state after the current edge.
REQ-025 i_flush=1: pointers and count to 0 next edge; flush overrides same-cycle read/write (both dropped, no error flags); o_r_data unchanged.
REQ-026 Single-entry case: write then read on consecutive cycles returns that word; o_tx_empty rises the edge of the read.

Reset
REQ-027 i_reset_n=0 asynchronously: pointers=0, count=0, o_r_data=0, o_tx_empty=1, o_full=0, o_afull=0, o_overflow=0, o_underflow=0.
REQ-028 Memory contents are not reset; stale data never observable since reads require count>0.
REQ-029 Reset mid-operation discards all entries; first read after release returns first post-reset write.

Configuration
REQ-030 Macro CAN_TX_FIFO_ERR_EN defined: o_overflow sets on a dropped write (REQ-022), o_underflow on an ignored read (REQ-023); both hold until i_err_clr=1; set has priority over same-cycle clear.
REQ-031 Macro CAN_TX_FIFO_ERR_EN undefined: o_overflow and o_underflow tied 0, i_err_clr ignored, no error-flag registers.

Verification
REQ-032 Reset, write 0x...01..0x...08 (DEPTH=8) -> o_full=1, o_count=8, o_afull from count 6; 8 reads return 01..08 in order, o_tx_empty=1 after 8th.
REQ-033 Full, i_w_en and i_r_en same cycle -> read returns oldest word, write dropped, o_count=7, o_overflow=1 (ERR_EN).
REQ-034 Empty, i_r_en pulse -> o_r_data unchanged, o_underflow=1 (ERR_EN) / 0 (no ERR_EN); i_err_clr clears flag next edge.
REQ-035 Count 4, continuous simultaneous read/write 20 cycles -> o_count stays 4, pointer wrap, data order preserved.
REQ-036 Count 5, i_flush with i_w_en same cycle -> o_count=0, o_tx_empty=1, no error flags; next write/read returns new word.
REQ-037 Count 3, i_reset_n low mid-cycle -> outputs at reset values immediately; after release o_tx_empty=1.
